duck_hit_ctl: RTL

Shot evaluator on the consumer side of the duck position interface: takes the duck's registered `xpos`/`ypos` together with the mouse cursor and left-button level, and decides hit or miss for every click. It produces a one-cycle `target_killed` pulse back toward the duck controller, keeps the shot budget per duck and keeps the score. It sits in Game_Control between the mouse interface and the duck controller and drives the HUD and score counters.

---
 rtl/game_pkg.sv | 34 +++
 rtl/duck_hit_ctl_hitbox_cmp.sv | 69 ++++++
 rtl/duck_hit_ctl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for Game_Control: the duck hitbox geometry (also used by
//   the duck controller), the shot-evaluator state type and a saturating
//   subtract helper for the hitbox lower bounds.
//
//   Contents:
//     DUCK_WIDTH, DUCK_HEIGHT  default hitbox size in pixels
//     HIT_MARGIN               extra pixels per side when DUCK_HIT_MARGIN_EN
//                              is defined
//     hit_state_t              duck_hit_ctl state encoding
//     sat_sub13()              13-bit subtract clamped at zero
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned DUCK_WIDTH  = 96;
    localparam int unsigned DUCK_HEIGHT = 32;
    localparam int unsigned HIT_MARGIN  = 4;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_ARMED,
        HS_EVAL,
        HS_HIT_HOLD,
        HS_MISS_HOLD
    } hit_state_t;

    // a - b, floored at zero rather than wrapping.
    function automatic logic [12:0] sat_sub13(input logic [12:0] a,
                                              input logic [12:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/duck_hit_ctl_hitbox_cmp.sv
// -----------------------------------------------------------------------------
// hitbox_cmp
//   Combinational rectangle containment check. Reports whether the point
//   (mx, my) lies inside the half-open box [dx, dx+BOX_W) x [dy, dy+BOX_H).
//   All arithmetic is done at 13 bits so the upper bounds cannot wrap.
//
//   Optional feature macro: DUCK_HIT_MARGIN_EN
//     When defined the box grows by HIT_MARGIN pixels on every side; the lower
//     bounds clamp at 0 instead of wrapping.
//
//   Ports:
//     mx_i, my_i  [11:0]  point to test (pixels)
//     dx_i, dy_i  [11:0]  box top-left corner (pixels)
//     hit_o               1 when the point is inside the box
// -----------------------------------------------------------------------------
module hitbox_cmp #(
    parameter int unsigned BOX_W = game_pkg::DUCK_WIDTH,
    parameter int unsigned BOX_H = game_pkg::DUCK_HEIGHT
) (
    input  logic [11:0] mx_i,
    input  logic [11:0] my_i,
    input  logic [11:0] dx_i,
    input  logic [11:0] dy_i,
    output logic        hit_o
);
    import game_pkg::*;

`ifdef DUCK_HIT_MARGIN_EN
    localparam int unsigned MARGIN = HIT_MARGIN;
`else
    localparam int unsigned MARGIN = 0;
`endif

    localparam logic [12:0] MARGIN13 = 13'(MARGIN);
    localparam logic [12:0] SPAN_X   = 13'(BOX_W + MARGIN);
    localparam logic [12:0] SPAN_Y   = 13'(BOX_H + MARGIN);

    logic [12:0] mx13;
    logic [12:0] my13;
    logic [12:0] dx13;
    logic [12:0] dy13;
    logic [12:0] x_lo;
    logic [12:0] x_hi;
    logic [12:0] y_lo;
    logic [12:0] y_hi;
    logic        in_x;
    logic        in_y;

    always_comb begin
        mx13 = {1'b0, mx_i};
        my13 = {1'b0, my_i};
        dx13 = {1'b0, dx_i};
        dy13 = {1'b0, dy_i};

        // Lower bound saturates at 0 so a duck hugging the left/top edge keeps
        // its margin clipped rather than wrapping to a huge value.
        x_lo = sat_sub13(dx13, MARGIN13);
        y_lo = sat_sub13(dy13, MARGIN13);

        // Upper bound is exclusive; max is 4095 + 96 + 4, well inside 13 bits.
        x_hi = dx13 + SPAN_X;
        y_hi = dy13 + SPAN_Y;

        in_x  = (mx13 >= x_lo) && (mx13 < x_hi);
        in_y  = (my13 >= y_lo) && (my13 < y_hi);
        hit_o = in_x && in_y;
    end

endmodule

// File: rtl/duck_hit_ctl.sv
// -----------------------------------------------------------------------------
// duck_hit_ctl
//   Shot evaluator for the duck game. Detects left-button click edges, captures
//   the cursor and duck coordinates on each accepted click, judges hit or miss
//   one cycle later, keeps the per-duck shot budget and the saturating score,
//   and holds for HOLD_CYCLES after a kill or an exhausted budget before
//   re-arming.
//
//   Optional feature macro: DUCK_HIT_MARGIN_EN (enlarges the hitbox by
//   HIT_MARGIN pixels per side; handled inside hitbox_cmp).
//
//   Parameters:
//     DUCK_WIDTH, DUCK_HEIGHT  hitbox size in pixels
//     SHOTS_PER_DUCK           shots per duck, 1..3
//     HOLD_CYCLES              cycles spent in HIT_HOLD / MISS_HOLD, >= 1
//     SCORE_MAX                score saturation value
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     game_enable              gameplay active while high
//     mouse_left               left-button level (synchronous to clk)
//     mouse_xpos, mouse_ypos   cursor position [11:0]
//     duck_xpos, duck_ypos     duck top-left corner [11:0]
//     shot_fired               1-cycle pulse per accepted click
//     target_killed            1-cycle pulse on a hit
//     round_missed             1-cycle pulse when the budget runs out
//     shots_left [1:0]         remaining shots for the current duck
//     score      [7:0]         saturating hit count
// -----------------------------------------------------------------------------
module duck_hit_ctl #(
    parameter int unsigned DUCK_WIDTH     = game_pkg::DUCK_WIDTH,
    parameter int unsigned DUCK_HEIGHT    = game_pkg::DUCK_HEIGHT,
    parameter int unsigned SHOTS_PER_DUCK = 3,
    parameter logic [19:0] HOLD_CYCLES    = 20'd650000,
    parameter int unsigned SCORE_MAX      = 99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_enable,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [11:0] duck_xpos,
    input  logic [11:0] duck_ypos,
    output logic        shot_fired,
    output logic        target_killed,
    output logic        round_missed,
    output logic [1:0]  shots_left,
    output logic [7:0]  score
);
    import game_pkg::*;

    localparam logic [1:0]  SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
    localparam logic [19:0] HOLD_RELOAD = HOLD_CYCLES - 20'd1;
    localparam logic [7:0]  SCORE_SAT   = 8'(SCORE_MAX);

    hit_state_t  state_q;
    logic        mouse_left_q;
    logic [19:0] hold_q;
    logic [11:0] cap_mx_q;
    logic [11:0] cap_my_q;
    logic [11:0] cap_dx_q;
    logic [11:0] cap_dy_q;
    logic [1:0]  shots_q;
    logic [7:0]  score_q;
    logic        shot_q;
    logic        kill_q;
    logic        miss_q;

    logic        click;
    logic        hit;
    logic [7:0]  score_d;

    assign click = mouse_left & ~mouse_left_q;

    always_comb begin
        score_d = score_q;
        if (score_q < SCORE_SAT) begin
            score_d = score_q + 8'd1;
        end
    end

    // Judged from the captured coordinates, so the result is stable for the
    // whole EVAL cycle regardless of live cursor/duck motion.
    hitbox_cmp #(
        .BOX_W (DUCK_WIDTH),
        .BOX_H (DUCK_HEIGHT)
    ) u_hitbox (
        .mx_i  (cap_mx_q),
        .my_i  (cap_my_q),
        .dx_i  (cap_dx_q),
        .dy_i  (cap_dy_q),
        .hit_o (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HS_IDLE;
            mouse_left_q <= 1'b0;
            hold_q       <= '0;
            cap_mx_q     <= '0;
            cap_my_q     <= '0;
            cap_dx_q     <= '0;
            cap_dy_q     <= '0;
            shots_q      <= '0;
            score_q      <= '0;
            shot_q       <= 1'b0;
            kill_q       <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
            shot_q       <= 1'b0;
            kill_q       <= 1'b0;
            miss_q       <= 1'b0;

            // Disable has priority over any click or verdict in the same
            // cycle; score and shot budget are left frozen until restart.
            if (!game_enable) begin
                state_q <= HS_IDLE;
            end else begin
                unique case (state_q)
                    HS_IDLE: begin
                        score_q <= '0;
                        shots_q <= SHOTS_INIT;
                        state_q <= HS_ARMED;
                    end

                    HS_ARMED: begin
                        if (click && (shots_q != '0)) begin
                            cap_mx_q <= mouse_xpos;
                            cap_my_q <= mouse_ypos;
                            cap_dx_q <= duck_xpos;
                            cap_dy_q <= duck_ypos;
                            shots_q  <= shots_q - 2'd1;
                            shot_q   <= 1'b1;
                            state_q  <= HS_EVAL;
                        end
                    end

                    HS_EVAL: begin
                        if (hit) begin
                            kill_q  <= 1'b1;
                            score_q <= score_d;
                            hold_q  <= HOLD_RELOAD;
                            state_q <= HS_HIT_HOLD;
                        end else if (shots_q == '0) begin
                            miss_q  <= 1'b1;
                            hold_q  <= HOLD_RELOAD;
                            state_q <= HS_MISS_HOLD;
                        end else begin
                            state_q <= HS_ARMED;
                        end
                    end

                    HS_HIT_HOLD, HS_MISS_HOLD: begin
                        if (hold_q == '0) begin
                            shots_q <= SHOTS_INIT;
                            state_q <= HS_ARMED;
                        end else begin
                            hold_q <= hold_q - 20'd1;
                        end
                    end

                    default: begin
                        state_q <= HS_IDLE;
                    end
                endcase
            end
        end
    end

    assign shot_fired    = shot_q;
    assign target_killed = kill_q;
    assign round_missed  = miss_q;
    assign shots_left    = shots_q;
    assign score         = score_q;

endmodule
